// File: rtl/genius_playback.sv
// Genius sequence playback: synchronises the divider toggle clocks, picks one as the step
// rate and lights one LED per sequence element with a dark gap between elements.
module genius_playback #(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              r_i,
    input  logic              c025_i,
    input  logic              c05_i,
    input  logic              c1_i,
    input  logic              c2_i,
    input  logic [1:0]        speed_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W:0]   len_i,
    output logic [ADDR_W-1:0] seq_addr_o,
    input  logic [1:0]        seq_data_i,
    output logic [3:0]        led_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {IDLE, WAIT, SHOW, GAP, DONE} state_t;

    localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    state_t            state, state_n;
    logic [3:0]        div_raw, sync1, sync2, dly, rise;
    logic              tick;
    logic [1:0]        speed_q, speed_n;
    logic [ADDR_W:0]   len_q, len_n, len_clamped;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [3:0]        led_n;
    logic              busy_n, done_n;
    logic              last_elem;

    function automatic logic [3:0] led_of(input logic [1:0] colour);
        return 4'b0001 << colour;
    endfunction

    assign div_raw = {c2_i, c1_i, c05_i, c025_i};

    // Edges are found per input ahead of the rate mux, so reselecting never fakes a tick.
    always_ff @(posedge clk_i) begin
        if (!r_i) begin
            sync1 <= '0;
            sync2 <= '0;
            dly   <= '0;
        end else begin
            sync1 <= div_raw;
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

    assign rise        = sync2 & ~dly;
    assign tick        = rise[speed_q];
    assign len_clamped = (len_i > MAX_LEN) ? MAX_LEN : len_i;
    assign last_elem   = ({1'b0, idx} == (len_q - LEN_ONE));
    assign seq_addr_o  = idx;

    always_ff @(posedge clk_i) begin
        if (!r_i) begin
            state   <= IDLE;
            speed_q <= '0;
            len_q   <= '0;
            idx     <= '0;
            led_o   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state   <= state_n;
            speed_q <= speed_n;
            len_q   <= len_n;
            idx     <= idx_n;
            led_o   <= led_n;
            busy_o  <= busy_n;
            done_o  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        speed_n = speed_q;
        len_n   = len_q;
        idx_n   = idx;
        led_n   = led_o;
        busy_n  = busy_o;
        done_n  = 1'b0;

        if (state != IDLE && abort_i) begin
            state_n = IDLE;
            idx_n   = '0;
            led_n   = '0;
            busy_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    led_n  = '0;
                    busy_n = 1'b0;
                    // An abort in the same cycle suppresses the start request.
                    if (start_i && !abort_i) begin
                        speed_n = speed_i;
                        len_n   = len_clamped;
                        idx_n   = '0;
                        if (len_clamped != '0) begin
                            state_n = WAIT;
                            busy_n  = 1'b1;
                        end else begin
                            state_n = DONE;
                        end
                    end
                end
                WAIT: begin
                    if (tick) begin
                        led_n   = led_of(seq_data_i);
                        state_n = SHOW;
                    end
                end
                SHOW: begin
                    if (tick) begin
                        led_n = '0;
                        if (last_elem) begin
                            state_n = DONE;
                        end else begin
                            idx_n   = idx + IDX_ONE;
                            state_n = GAP;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        led_n   = led_of(seq_data_i);
                        state_n = SHOW;
                    end
                end
                DONE: begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    led_n   = '0;
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_genius_playback.sv
// Self-checking bench for genius_playback: hand sequences for reset/abort/len=0 corners and a
// vector table of playbacks whose expected LED stream is queued at start and popped on change.
module tb_genius_playback;

    typedef struct {
        logic [1:0] speed;
        logic [4:0] len_req;
        int         half;
        int         start_cycles;
        int         mid_action;
        int         exp_len;
    } vec_t;

    typedef struct packed {
        logic [3:0] led;
        logic [3:0] addr;
    } exp_t;

    logic       clk = 1'b0;
    logic       r_i, start_i, abort_i;
    logic [1:0] speed_i;
    logic [4:0] len_i;
    logic [3:0] c_gen = '0;
    logic       c_man, man_mode, c1_w;
    logic [3:0] seq_addr_o;
    logic [1:0] seq_data_i;
    logic [3:0] led_o;
    logic       busy_o, done_o;
    logic [1:0] ram [16];
    int         half [4] = '{7, 9, 6, 4};
    int         gcnt [4] = '{0, 0, 0, 0};
    int         cyc = 0;
    int         n_vec = 0;
    int         n_miss = 0;

    exp_t       exp_q [$];
    logic [3:0] prev_led = '0;
    bit         mon_en = 1'b0;
    bit         first_chg = 1'b1;
    int         period = 0;
    int         last_change = 0;
    int         last_on = 0;

    always #5 clk = ~clk;

    assign c1_w       = man_mode ? c_man : c_gen[2];
    assign seq_data_i = ram[seq_addr_o];

    genius_playback #(.ADDR_W(4)) dut (
        .clk_i      (clk),
        .r_i        (r_i),
        .c025_i     (c_gen[0]),
        .c05_i      (c_gen[1]),
        .c1_i       (c1_w),
        .c2_i       (c_gen[3]),
        .speed_i    (speed_i),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .len_i      (len_i),
        .seq_addr_o (seq_addr_o),
        .seq_data_i (seq_data_i),
        .led_o      (led_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Free-running divider stand-ins: each input toggles every half[i] clocks.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (gcnt[i] + 1 >= half[i]) begin
                gcnt[i]  <= 0;
                c_gen[i] <= ~c_gen[i];
            end else begin
                gcnt[i] <= gcnt[i] + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (mon_en && led_o !== prev_led) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("[TB] FAIL extra_led_change: got led %b, expected no further change", led_o);
            end else begin
                e = exp_q.pop_front();
                checkOutput("led", led_o, e.led);
                checkOutput("addr", seq_addr_o, e.addr);
            end
            if (!first_chg) checkRange("phase_len", cyc - last_change, period - 1, period + 1);
            first_chg   = 1'b0;
            last_change = cyc;
            if (led_o != 4'b0000) last_on = cyc;
        end
        prev_led = led_o;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
    endtask

    task automatic stepN(input int n);
        repeat (n) step();
    endtask

    task automatic pulseC1();
        c_man = 1'b1;
        stepN(3);
        c_man = 1'b0;
        stepN(3);
    endtask

    task automatic applyStimulus(input vec_t v, input int vi);
        int c;
        int bound;
        int extra;
        bit mid_done;
        bit mid_pending;
        half[v.speed] = v.half;
        for (int i = 0; i < 16; i++) ram[i] = 2'($urandom_range(0, 3));
        if (vi == 0) begin
            ram[0] = 2'd2;
            ram[1] = 2'd0;
            ram[2] = 2'd3;
        end
        stepN(2 * v.half + 2);
        for (int i = 0; i < v.exp_len; i++) begin
            exp_q.push_back('{led: 4'b0001 << ram[i], addr: 4'(i)});
            exp_q.push_back('{led: 4'b0000, addr: (i == v.exp_len - 1) ? 4'(i) : 4'(i + 1)});
        end
        period    = 2 * v.half;
        first_chg = 1'b1;
        mon_en    = 1'b1;
        speed_i   = v.speed;
        len_i     = v.len_req;
        start_i   = 1'b1;
        stepN(v.start_cycles);
        start_i = 1'b0;
        speed_i = v.speed ^ 2'd1;
        len_i   = 5'd1;
        checkOutput("busy_after_start", busy_o, 1);
        bound       = (4 * v.exp_len + 6) * v.half + 50;
        c           = 0;
        mid_done    = 1'b0;
        mid_pending = 1'b0;
        while (!done_o && c < bound) begin
            if (mid_pending) begin
                start_i     = 1'b0;
                mid_pending = 1'b0;
            end
            step();
            c++;
            if (!mid_done && led_o != 4'b0000 && v.mid_action != 0) begin
                mid_done = 1'b1;
                if (v.mid_action == 1) begin
                    start_i     = 1'b1;
                    len_i       = 5'd2;
                    mid_pending = 1'b1;
                end else begin
                    speed_i = 2'd0;
                end
            end
        end
        start_i = 1'b0;
        checkOutput("done_seen", done_o, 1);
        if (done_o) begin
            checkRange("done_delay", cyc - last_on, period - 1, period + 1);
            checkOutput("busy_at_done", busy_o, 0);
        end
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (done_o) extra++;
        end
        checkOutput("done_single", extra, 0);
        checkOutput("sb_empty", exp_q.size(), 0);
        exp_q.delete();
        mon_en = 1'b0;
    endtask

    initial begin
        vec_t vecs [6];
        int   act;
        vecs[0] = '{2'd2, 5'd3,  10, 1, 0, 3};
        vecs[1] = '{2'd0, 5'd5,  4,  3, 0, 5};
        vecs[2] = '{2'd1, 5'd1,  6,  1, 0, 1};
        vecs[3] = '{2'd3, 5'd20, 5,  1, 1, 16};
        vecs[4] = '{2'd2, 5'd16, 3,  1, 0, 16};
        vecs[5] = '{2'd3, 5'd4,  5,  1, 2, 4};

        for (int i = 0; i < 16; i++) ram[i] = 2'd0;
        r_i      = 1'b0;
        start_i  = 1'b0;
        abort_i  = 1'b0;
        speed_i  = 2'd0;
        len_i    = 5'd0;
        man_mode = 1'b0;
        c_man    = 1'b0;
        stepN(3);
        r_i = 1'b1;
        step();
        checkOutput("reset_led", led_o, 0);
        checkOutput("reset_busy", busy_o, 0);
        checkOutput("reset_done", done_o, 0);
        checkOutput("reset_addr", seq_addr_o, 0);

        // Zero-length request goes straight to DONE without ever raising busy.
        speed_i = 2'd2;
        len_i   = 5'd0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        checkOutput("len0_busy_c1", busy_o, 0);
        checkOutput("len0_done_c1", done_o, 0);
        step();
        checkOutput("len0_done_c2", done_o, 1);
        checkOutput("len0_busy_c2", busy_o, 0);
        checkOutput("len0_led_c2", led_o, 0);
        step();
        checkOutput("len0_done_c3", done_o, 0);
        checkOutput("len0_busy_c3", busy_o, 0);

        len_i   = 5'd3;
        abort_i = 1'b1;
        start_i = 1'b1;
        step();
        abort_i = 1'b0;
        start_i = 1'b0;
        checkOutput("abort_start_idle_busy", busy_o, 0);
        step();
        checkOutput("abort_start_idle_busy2", busy_o, 0);

        // Hand-driven c1 for exact tick placement.
        man_mode = 1'b1;
        c_man    = 1'b0;
        stepN(5);
        ram[0]  = 2'd1;
        ram[1]  = 2'd3;
        ram[2]  = 2'd2;
        speed_i = 2'd2;
        len_i   = 5'd3;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        stepN(3);
        checkOutput("wait_busy", busy_o, 1);
        checkOutput("wait_led", led_o, 0);
        c_man = 1'b1;
        stepN(2);
        checkOutput("tick_latency_early", led_o, 0);
        step();
        checkOutput("tick_latency_led", led_o, 4'b0010);
        c_man = 1'b0;
        stepN(3);
        c_man = 1'b1;
        stepN(3);
        checkOutput("gap_led", led_o, 0);
        checkOutput("gap_addr", seq_addr_o, 1);
        c_man = 1'b0;
        stepN(3);
        c_man = 1'b1;
        stepN(2);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        checkOutput("abort_led", led_o, 0);
        checkOutput("abort_busy", busy_o, 0);
        checkOutput("abort_addr", seq_addr_o, 0);
        checkOutput("abort_done", done_o, 0);
        act = 0;
        for (int k = 0; k < 30; k++) begin
            if (k % 5 == 0) c_man = ~c_man;
            step();
            if (led_o != 4'b0000 || done_o || busy_o) act++;
        end
        checkOutput("abort_quiet", act, 0);

        c_man = 1'b0;
        stepN(3);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        stepN(3);
        pulseC1();
        pulseC1();
        pulseC1();
        checkOutput("pre_reset_led", led_o, 4'b1000);
        checkOutput("pre_reset_addr", seq_addr_o, 1);
        r_i = 1'b0;
        step();
        r_i = 1'b1;
        checkOutput("midshow_reset_led", led_o, 0);
        checkOutput("midshow_reset_busy", busy_o, 0);
        checkOutput("midshow_reset_addr", seq_addr_o, 0);
        stepN(10);
        c_man = 1'b1;
        act   = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (led_o != 4'b0000 || done_o || busy_o) act++;
        end
        checkOutput("post_reset_quiet", act, 0);

        c_man    = 1'b0;
        man_mode = 1'b0;
        stepN(5);
        for (int vi = 0; vi < 6; vi++) begin
            $display("[TB] playback vector %0d: speed=%0d len=%0d", vi, vecs[vi].speed, vecs[vi].len_req);
            applyStimulus(vecs[vi], vi);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
